// File: rtl/warp_module_pkg.sv
// Shared constants and types for the warp address generator and its pixel RAM.
package warp_module_pkg;

    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int ADDR_W = 21;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_module.sv
// Single-port 2^21 x 8 pixel memory, synchronous read-first with 1-cycle latency.
module ram_module
    import warp_module_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] data,
    input  addr_t      addr,
    output logic [7:0] q
);

    logic [7:0] mem [2**ADDR_W];

    // Storage has no reset so contents survive rst and the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/warp_module_axis.sv
// One axis of the warp: input clamp, optional mirror, signed shift, saturation.
module warp_module_axis #(
    parameter int SIZE   = 640,
    parameter int MIRROR = 0,
    parameter int SHIFT  = 0
) (
    input  logic [9:0] idx,
    output logic [9:0] pos
);

    localparam logic        [9:0]  MAX_POS = 10'(SIZE - 1);
    localparam logic signed [11:0] SHIFT12 = 12'(SHIFT);

    logic        [9:0]  clamped;
    logic        [9:0]  mirrored;
    logic signed [11:0] shifted;

    // 12-bit signed holds every mirrored index plus any shift in -1023..1023.
    always_comb begin
        clamped  = (idx > MAX_POS) ? MAX_POS : idx;
        mirrored = (MIRROR != 0) ? (MAX_POS - clamped) : clamped;
        shifted  = $signed({2'b00, mirrored}) + SHIFT12;
        if (shifted < 12'sd0) begin
            pos = '0;
        end else if (shifted > $signed({2'b00, MAX_POS})) begin
            pos = MAX_POS;
        end else begin
            pos = shifted[9:0];
        end
    end

endmodule

// File: rtl/warp_module.sv
// Maps a source (row, column) to a destination linear pixel offset, one result per clock.
module warp_module
    import warp_module_pkg::*;
#(
    parameter int IMG_W    = warp_module_pkg::IMG_W,
    parameter int IMG_H    = warp_module_pkg::IMG_H,
    parameter int MIRROR_X = 1,
    parameter int MIRROR_Y = 0,
    parameter int DX       = 0,
    parameter int DY       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  j,
    input  logic [9:0]  i,
    output addr_t       out
);

    logic [9:0] axisIn  [2];
    logic [9:0] axisPos [2];
    addr_t      rowTerm;
    addr_t      linear;

    assign axisIn[0] = j;
    assign axisIn[1] = i;

    // Axis 0 is the column, axis 1 is the row.
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        warp_module_axis #(
            .SIZE   ((gi == 0) ? IMG_W    : IMG_H),
            .MIRROR ((gi == 0) ? MIRROR_X : MIRROR_Y),
            .SHIFT  ((gi == 0) ? DX       : DY)
        ) u_axis (
            .idx (axisIn[gi]),
            .pos (axisPos[gi])
        );
    end

    if (IMG_W == 640) begin : g_mul640
        assign rowTerm = (addr_t'(axisPos[1]) << 9) + (addr_t'(axisPos[1]) << 7);
    end else begin : g_mulGeneric
        assign rowTerm = addr_t'(axisPos[1]) * addr_t'(IMG_W);
    end

    assign linear = rowTerm + addr_t'(axisPos[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= linear;
        end
    end

endmodule

// File: tb/tb_warp_module.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor checks one cycle later.
module tb_warp_module;
    import warp_module_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  j = '0;
    logic [9:0]  i = '0;
    logic        we = 1'b0;
    logic [7:0]  data = '0;
    addr_t       addr = '0;
    addr_t       out0, out1, out2;
    logic [7:0]  q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string    name;
        bit [3:0] en;
        int       e0;
        int       e1;
        int       e2;
        int       e3;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    warp_module u_dut0 (.clk(clk), .rst(rst), .j(j), .i(i), .out(out0));
    warp_module #(.MIRROR_X(0), .DX(10))  u_dut1 (.clk(clk), .rst(rst), .j(j), .i(i), .out(out1));
    warp_module #(.MIRROR_X(0), .DX(-10)) u_dut2 (.clk(clk), .rst(rst), .j(j), .i(i), .out(out2));
    ram_module u_ram (.clk(clk), .rst(rst), .we(we), .data(data), .addr(addr), .q(q));

    task automatic check(input string nm, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d, required %0d", nm, what, act, req);
        end
    endtask

    // en bits: 0=default warp, 1=DX=+10 warp, 2=DX=-10 warp, 3=ram q
    task automatic drive(input string nm, input bit r, input int ii, input int jj,
                         input bit w, input int d, input int a, input bit [3:0] en,
                         input int e0, input int e1, input int e2, input int e3);
        exp_t e;
        @(negedge clk);
        rst  = r;
        i    = 10'(ii);
        j    = 10'(jj);
        we   = w;
        data = 8'(d);
        addr = addr_t'(a);
        e.name = nm; e.en = en; e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3;
        expQ.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.en[0]) check(e.name, "out0", int'(out0), e.e0);
                if (e.en[1]) check(e.name, "out1", int'(out1), e.e1);
                if (e.en[2]) check(e.name, "out2", int'(out2), e.e2);
                if (e.en[3]) check(e.name, "q",    int'(q),    e.e3);
                $display("txn %-12s out0=%0d out1=%0d out2=%0d q=%0d", e.name, out0, out1, out2, q);
            end
        end
    end

    initial begin : stimulus
        //    name          rst  i    j    we data  addr    en       e0      e1      e2      e3
        drive("reset0",     1,   5,   5,   0, 0,    0,      4'hF,    0,      0,      0,      0);
        drive("reset1",     1,   5,   5,   0, 0,    0,      4'hF,    0,      0,      0,      0);
        drive("release",    0,   0,   5,   0, 0,    0,      4'h7,    634,    15,     0,      0);
        drive("origin",     0,   0,   0,   0, 0,    0,      4'h7,    639,    10,     0,      0);
        drive("corner",     0,   479, 639, 0, 0,    0,      4'h7,    306560, 307199, 307189, 0);
        drive("row1col0",   0,   1,   0,   0, 0,    0,      4'h1,    1279,   0,      0,      0);
        drive("row1col1",   0,   1,   1,   0, 0,    0,      4'h1,    1278,   0,      0,      0);
        drive("inclamp",    0,   600, 700, 0, 0,    0,      4'h7,    306560, 307199, 307189, 0);
        drive("inclampmax", 0,   1023,1023,0, 0,    0,      4'h7,    306560, 307199, 307189, 0);
        drive("mid55",      0,   5,   5,   0, 0,    0,      4'h1,    3834,   0,      0,      0);
        drive("dxsathi",    0,   2,   635, 0, 0,    0,      4'h7,    1284,   1919,   1905,   0);
        drive("dxsatlo",    0,   2,   3,   0, 0,    0,      4'h7,    1916,   1293,   1280,   0);
        drive("dxedge",     0,   0,   629, 0, 0,    0,      4'h7,    10,     639,    619,    0);
        drive("ramwrA5",    0,   0,   0,   1, 'hA5, 400000, 4'h1,    639,    0,      0,      0);
        drive("ramrdA5",    0,   0,   0,   0, 0,    400000, 4'h8,    0,      0,      0,      'hA5);
        drive("ramcollide", 0,   0,   0,   1, 'h3C, 400000, 4'h8,    0,      0,      0,      'hA5);
        drive("ramrd3C",    0,   0,   0,   0, 0,    400000, 4'h8,    0,      0,      0,      'h3C);
        drive("ramreset",   1,   0,   0,   0, 0,    400000, 4'h9,    0,      0,      0,      0);
        drive("ramkeep",    0,   0,   0,   0, 0,    400000, 4'h9,    639,    0,      0,      'h3C);
        // Bounded drain: the monitor consumes one entry per clock.
        for (int n = 0; n < 20 && expQ.size() > 0; n++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
